// File: rtl/ram_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_write_arbiter_if : LA0/LA1 write clients + DDR3 app write port bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface ram_write_arbiter_if;
  logic         la0_wr_en;
  logic         la0_wr_valid;
  logic [28:0]  la0_wr_addr;
  logic [127:0] la0_wr_data;
  logic         la0_wr_ack;

  logic         la1_wr_en;
  logic         la1_wr_valid;
  logic [28:0]  la1_wr_addr;
  logic [127:0] la1_wr_data;
  logic         la1_wr_ack;

  logic [28:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [255:0] app_wdf_data;
  logic         app_wdf_end;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_rdy;

  logic [1:0]   grant;
  logic         busy;

  // slave: the arbiter, serving both LA clients and driving the controller.
  modport slave (
    input  la0_wr_en, la0_wr_valid, la0_wr_addr, la0_wr_data,
    output la0_wr_ack,
    input  la1_wr_en, la1_wr_valid, la1_wr_addr, la1_wr_data,
    output la1_wr_ack,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end,
    output app_wdf_mask, app_wdf_wren,
    input  app_rdy, app_wdf_rdy,
    output grant, busy
  );

  // master: the surroundings (LA capture datapaths and controller UI).
  modport master (
    output la0_wr_en, la0_wr_valid, la0_wr_addr, la0_wr_data,
    input  la0_wr_ack,
    output la1_wr_en, la1_wr_valid, la1_wr_addr, la1_wr_data,
    input  la1_wr_ack,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end,
    input  app_wdf_mask, app_wdf_wren,
    output app_rdy, app_wdf_rdy,
    input  grant, busy
  );
endinterface

`default_nettype wire

// File: rtl/ram_write_arbiter.sv
// ---------------------------------------------------------------------------
// ram_write_arbiter : gathers 2x128b beats per client, round-robin with bounded
// bursts, one DDR3 write command per 256b block.                 Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ram_write_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter logic [2:0]  CMD_WRITE = 3'b000
) (
  input  logic          clk_ram,
  input  logic          rst_n,
  ram_write_arbiter_if.slave bus_if
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic         last_owner_q, last_owner_d;
  logic [7:0]   burst_cnt_q, burst_cnt_d;
  logic [28:0]  addr_q, addr_d;
  logic [255:0] data_q, data_d;
  logic         app_en_q, app_en_d;
  logic         wren_q, wren_d;

  logic         own_en;
  logic         own_valid;
  logic [28:0]  own_addr;
  logic [127:0] own_data;
  logic         in_beat;
  logic         cmd_done;
  logic         data_done;
  logic [8:0]   burst_next;

  assign own_en    = grant_q[1] ? bus_if.la1_wr_en    : bus_if.la0_wr_en;
  assign own_valid = grant_q[1] ? bus_if.la1_wr_valid : bus_if.la0_wr_valid;
  assign own_addr  = grant_q[1] ? bus_if.la1_wr_addr  : bus_if.la0_wr_addr;
  assign own_data  = grant_q[1] ? bus_if.la1_wr_data  : bus_if.la0_wr_data;

  assign in_beat = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign bus_if.la0_wr_ack = in_beat & grant_q[0] & bus_if.la0_wr_valid;
  assign bus_if.la1_wr_ack = in_beat & grant_q[1] & bus_if.la1_wr_valid;

  // A handshake counts as done if it already completed or completes this cycle.
  assign cmd_done   = ~app_en_q | bus_if.app_rdy;
  assign data_done  = ~wren_q   | bus_if.app_wdf_rdy;
  assign burst_next = {1'b0, burst_cnt_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    app_en_d     = app_en_q & ~bus_if.app_rdy;
    wren_d       = wren_q & ~bus_if.app_wdf_rdy;

    case (state_q)
      ST_IDLE: begin
        if (bus_if.la0_wr_en || bus_if.la1_wr_en) begin
          // LA0 wins a tie only when LA1 owned the port last.
          grant_d     = (bus_if.la0_wr_en && (!bus_if.la1_wr_en || last_owner_q)) ? 2'b01 : 2'b10;
          burst_cnt_d = 8'd0;
          state_d     = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (own_valid) begin
          data_d[127:0] = own_data;
          addr_d        = own_addr & 29'h1FFF_FFF8;
          state_d       = ST_BEAT1;
        end
      end
      ST_BEAT1: begin
        if (own_valid) begin
          data_d[255:128] = own_data;
          app_en_d        = 1'b1;
          wren_d          = 1'b1;
          state_d         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_done && data_done) begin
          burst_cnt_d = burst_next[7:0];
          if (own_en && (burst_next < 9'(MAX_BURST))) begin
            state_d = ST_BEAT0;
          end else begin
            last_owner_d = grant_q[1];
            grant_d      = 2'b00;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= 8'd0;
      addr_q       <= '0;
      data_q       <= '0;
      app_en_q     <= 1'b0;
      wren_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      app_en_q     <= app_en_d;
      wren_q       <= wren_d;
    end
  end

  assign bus_if.app_addr     = addr_q;
  assign bus_if.app_cmd      = CMD_WRITE;
  assign bus_if.app_en       = app_en_q;
  assign bus_if.app_wdf_data = data_q;
  assign bus_if.app_wdf_wren = wren_q;
  assign bus_if.app_wdf_end  = wren_q;
  assign bus_if.app_wdf_mask = 32'd0;
  assign bus_if.grant        = grant_q;
  assign bus_if.busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire
